// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - sequencing and coefficient controller for a 33-tap transposed-form FIR datapath
module fir_seq_ctrl #(
  parameter int TAPS = 33,
  parameter int CW   = 16,
  parameter int DW   = 3,
  parameter int AW   = 6
) (
  input  logic               iClk_12M,
  input  logic               iRst,
  input  logic               iStart,
  input  logic               iStop,
  input  logic               iCoeffWe,
  input  logic [AW-1:0]      iCoeffAddr,
  input  logic [CW-1:0]      iCoeffData,
  input  logic               iSampleValid,
  input  logic [DW-1:0]      iSample,
  output logic               oSampleReady,
  output logic [DW-1:0]      oFirIn,
  output logic               oEnAcc,
  output logic [TAPS*CW-1:0] oCoeffBus,
  output logic               oOutValid,
  output logic [1:0]         oState,
  output logic               oCoeffErr
);

  localparam int FCW = $clog2(TAPS - 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(TAPS - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FLUSH = 2'b10
  } state_t;

  state_t         state, next_state;
  logic [FCW-1:0] flush_cnt, flush_cnt_next;
  logic           zero_live;
  logic           accept, flush_issue, coeff_wr, coeff_rej, addr_ok;
  logic [CW-1:0]  coeff [TAPS];

  assign addr_ok      = (iCoeffAddr < AW'(TAPS));
  assign oSampleReady = (state == S_RUN);
  assign oState       = state;

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) state <= S_IDLE;
    else      state <= next_state;
  end

  // zero_live marks that the pulse now on oEnAcc is a flush zero; the
  // counter advances on those, so FLUSH lasts until the last zero is shown.
  always_comb begin
    next_state     = state;
    flush_cnt_next = flush_cnt;
    accept         = 1'b0;
    flush_issue    = 1'b0;
    coeff_wr       = 1'b0;
    coeff_rej      = 1'b0;
    case (state)
      S_IDLE: begin
        coeff_wr  = iCoeffWe && addr_ok;
        coeff_rej = iCoeffWe && !addr_ok;
        if (iStart && !iStop) next_state = S_RUN;
      end
      S_RUN: begin
        accept    = iSampleValid;
        coeff_rej = iCoeffWe;
        if (iStop) next_state = S_FLUSH;
      end
      S_FLUSH: begin
        coeff_rej = iCoeffWe;
        if (!zero_live) begin
          flush_issue = 1'b1;
        end else if (flush_cnt == FLUSH_LAST) begin
          next_state     = S_IDLE;
          flush_cnt_next = '0;
        end else begin
          flush_issue    = 1'b1;
          flush_cnt_next = flush_cnt + FCW'(1);
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      oFirIn    <= '0;
      oEnAcc    <= 1'b0;
      oOutValid <= 1'b0;
      oCoeffErr <= 1'b0;
      zero_live <= 1'b0;
      flush_cnt <= '0;
    end else begin
      oEnAcc    <= accept | flush_issue;
      oOutValid <= oEnAcc;
      oCoeffErr <= coeff_rej;
      zero_live <= flush_issue;
      flush_cnt <= flush_cnt_next;
      if (accept)           oFirIn <= iSample;
      else if (flush_issue) oFirIn <= '0;
    end
  end

  // Writes only land in IDLE, so the datapath never sees a mid-stream change.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      for (int k = 0; k < TAPS; k++) coeff[k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++)
        if (coeff_wr && iCoeffAddr == AW'(k)) coeff[k] <= iCoeffData;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_bus
    assign oCoeffBus[k*CW +: CW] = coeff[k];
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - self-checking bench for fir_seq_ctrl with an attached FIR datapath model
`timescale 1ns/1ps
module tb_fir_seq_ctrl;
  localparam int TAPS = 33, CW = 16, DW = 3, AW = 6;

  logic               clk = 1'b0, rst = 1'b1;
  logic               start = 1'b0, stop = 1'b0, coeff_we = 1'b0;
  logic [AW-1:0]      coeff_addr = '0;
  logic [CW-1:0]      coeff_data = '0;
  logic               sample_valid = 1'b0;
  logic [DW-1:0]      sample = '0;
  logic               sample_ready, en_acc, out_valid, coeff_err;
  logic [DW-1:0]      fir_in;
  logic [TAPS*CW-1:0] coeff_bus;
  logic [1:0]         state;

  fir_seq_ctrl #(.TAPS(TAPS), .CW(CW), .DW(DW), .AW(AW)) dut (
    .iClk_12M(clk), .iRst(rst), .iStart(start), .iStop(stop),
    .iCoeffWe(coeff_we), .iCoeffAddr(coeff_addr), .iCoeffData(coeff_data),
    .iSampleValid(sample_valid), .iSample(sample), .oSampleReady(sample_ready),
    .oFirIn(fir_in), .oEnAcc(en_acc), .oCoeffBus(coeff_bus), .oOutValid(out_valid),
    .oState(state), .oCoeffErr(coeff_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic [TAPS*CW-1:0] act, input logic [TAPS*CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: coefficient bank and direct-form FIR over the samples the bench feeds
  logic [CW-1:0] exp_coef [TAPS];
  logic [DW-1:0] hist [TAPS];
  logic [DW-1:0] fir_q [$];
  int            y_q [$];

  function automatic logic [TAPS*CW-1:0] exp_bus();
    logic [TAPS*CW-1:0] b;
    for (int k = 0; k < TAPS; k++) b[k*CW +: CW] = exp_coef[k];
    return b;
  endfunction

  task automatic push_sample(input logic [DW-1:0] s);
    int acc;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    acc = 0;
    for (int k = 0; k < TAPS; k++)
      acc += int'($signed(hist[k])) * int'($signed(exp_coef[k]));
    fir_q.push_back(s);
    y_q.push_back(acc);
  endtask

  task automatic clear_model();
    for (int k = 0; k < TAPS; k++) begin
      hist[k]     = '0;
      exp_coef[k] = '0;
    end
    fir_q.delete();
    y_q.delete();
  endtask

  // Transposed-form datapath driven by the controller outputs
  int acc_z [TAPS-1];
  int y_dp;
  always @(posedge clk or posedge rst) begin : dp
    int x;
    if (rst) begin
      for (int k = 0; k < TAPS - 1; k++) acc_z[k] = 0;
      y_dp = 0;
    end else if (en_acc) begin
      x    = int'($signed(fir_in));
      y_dp = x * int'($signed(coeff_bus[0 +: CW])) + acc_z[0];
      for (int k = 0; k < TAPS - 2; k++)
        acc_z[k] = x * int'($signed(coeff_bus[(k+1)*CW +: CW])) + acc_z[k+1];
      acc_z[TAPS-2] = x * int'($signed(coeff_bus[(TAPS-1)*CW +: CW]));
    end
  end

  // Scoreboard: every oEnAcc and oOutValid must match a queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (en_acc) begin
        check("en_expected", 32'(fir_q.size() != 0), 1);
        if (fir_q.size() != 0) check("sb_fir_in", fir_in, fir_q.pop_front());
      end
      if (out_valid) begin
        check("valid_expected", 32'(y_q.size() != 0), 1);
        if (y_q.size() != 0) check("sb_y", y_dp, y_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
    logic          err;
  } cw_vec_t;

  cw_vec_t tbl [7];
  logic    gap [6];
  logic    prev;

  initial begin
    tbl[0] = '{1'b1, 6'd0,  16'h0001, 1'b0};
    tbl[1] = '{1'b1, 6'd32, 16'h8000, 1'b0};
    tbl[2] = '{1'b1, 6'd40, 16'h1234, 1'b1};
    tbl[3] = '{1'b0, 6'd5,  16'hFFFF, 1'b0};
    tbl[4] = '{1'b1, 6'd33, 16'h5555, 1'b1};
    tbl[5] = '{1'b1, 6'd63, 16'h7777, 1'b1};
    tbl[6] = '{1'b1, 6'd1,  16'hABCD, 1'b0};
    gap[0] = 1'b1; gap[1] = 1'b0; gap[2] = 1'b1;
    gap[3] = 1'b1; gap[4] = 1'b0; gap[5] = 1'b1;
    clear_model();

    #2;
    check("rst_state", state, 0);
    check("rst_ready", sample_ready, 0);
    check("rst_en", en_acc, 0);
    check("rst_valid", out_valid, 0);
    check("rst_fir", fir_in, 0);
    check("rst_err", coeff_err, 0);
    check_bus("rst_bus", coeff_bus, '0);
    cyc(2);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 7; i++) begin
      coeff_we = tbl[i].we; coeff_addr = tbl[i].addr; coeff_data = tbl[i].data;
      if (tbl[i].we && tbl[i].addr < AW'(TAPS)) exp_coef[tbl[i].addr] = tbl[i].data;
      cyc();
      check($sformatf("tbl%0d_err", i), coeff_err, tbl[i].err);
      check_bus($sformatf("tbl%0d_bus", i), coeff_bus, exp_bus());
    end
    coeff_we = 1'b0;

    for (int k = 0; k < TAPS; k++) begin
      coeff_we = 1'b1; coeff_addr = AW'(k); coeff_data = CW'(k + 1);
      exp_coef[k] = CW'(k + 1);
      cyc();
    end
    coeff_we = 1'b0;
    cyc();
    check_bus("ramp_bus", coeff_bus, exp_bus());

    start = 1'b1; stop = 1'b1;
    cyc();
    check("start_stop_state", state, 0);
    check("start_stop_ready", sample_ready, 0);
    stop = 1'b0;
    cyc();
    check("start_state", state, 1);
    check("start_ready", sample_ready, 1);
    start = 1'b0;

    sample_valid = 1'b1; sample = 3'sd1;
    push_sample(sample);
    cyc();
    check("impulse_en", en_acc, 1);
    check("impulse_fir", fir_in, 1);
    sample = '0;
    for (int i = 0; i < 40; i++) begin
      push_sample(sample);
      cyc();
    end
    sample_valid = 1'b0;
    cyc(3);
    check("impulse_drained", 32'(y_q.size()), 0);

    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample_valid = gap[i];
      sample = DW'($urandom_range(0, 7));
      if (gap[i]) push_sample(sample);
      cyc();
      check($sformatf("gap%0d_en", i), en_acc, gap[i]);
      check($sformatf("gap%0d_valid", i), out_valid, prev);
      prev = gap[i];
    end
    sample_valid = 1'b0;
    cyc();
    check("gap_valid_tail", out_valid, prev);
    cyc(2);

    coeff_we = 1'b1; coeff_addr = 6'd3; coeff_data = 16'h00FF;
    cyc();
    coeff_we = 1'b0;
    check("run_wr_err", coeff_err, 1);
    check("run_wr_slice3", coeff_bus[3*CW +: CW], exp_coef[3]);
    cyc();
    check("run_wr_err_clear", coeff_err, 0);

    sample_valid = 1'b1; sample = 3'b110; stop = 1'b1;
    push_sample(sample);
    for (int i = 0; i < TAPS - 1; i++) push_sample('0);
    cyc();
    sample_valid = 1'b0; stop = 1'b0; start = 1'b1;
    check("stop_state", state, 2);
    check("stop_en", en_acc, 1);
    check("stop_fir", fir_in, 3'b110);
    check("stop_ready", sample_ready, 0);
    for (int i = 0; i < TAPS - 1; i++) begin
      cyc();
      check($sformatf("flush%0d_en", i), en_acc, 1);
      check($sformatf("flush%0d_fir", i), fir_in, 0);
      check($sformatf("flush%0d_state", i), state, 2);
    end
    start = 1'b0;
    cyc();
    check("flush_end_state", state, 0);
    check("flush_end_en", en_acc, 0);
    check("flush_last_valid", out_valid, 1);
    cyc();
    check("flush_after_valid", out_valid, 0);
    check("flush_fir_q_empty", 32'(fir_q.size()), 0);
    check("flush_y_q_empty", 32'(y_q.size()), 0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1; sample = DW'(i + 1);
      push_sample(sample);
      cyc();
    end
    sample_valid = 1'b0;
    cyc(2);
    stop = 1'b1;
    for (int i = 0; i < TAPS - 1; i++) push_sample('0);
    cyc();
    stop = 1'b0;
    cyc(11);
    check("rerun_pre_reset_state", state, 2);
    #2;
    rst = 1'b1;
    #1;
    clear_model();
    check("midrst_state", state, 0);
    check("midrst_en", en_acc, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_fir", fir_in, 0);
    check("midrst_ready", sample_ready, 0);
    check_bus("midrst_bus", coeff_bus, '0);
    cyc();
    rst = 1'b0;
    cyc(3);
    check("post_rst_state", state, 0);
    check("post_rst_en", en_acc, 0);
    check("post_rst_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
